// File: rtl/abc_seq_monitor.sv
// Sequence monitor: checks a, then a run of b&&c samples of MIN_LEN..MAX_LEN, then a terminator.
// It reports pass/fail pulses, the cause of the last failure, the run length and saturating counters.
module abc_seq_monitor #(
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       pass,
    output logic       fail,
    output logic [1:0] fail_code,
    output logic       busy,
    output logic [7:0] run_len,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam logic [1:0] CODE_SHORT    = 2'd0;
    localparam logic [1:0] CODE_NO_START = 2'd1;
    localparam logic [1:0] CODE_OVERFLOW = 2'd2;
    localparam logic [1:0] CODE_ILLEGAL  = 2'd3;

    localparam logic [7:0] MIN_L = 8'(MIN_LEN);
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       pass_q, pass_d;
    logic       fail_q, fail_d;
    logic [1:0] fail_code_q, fail_code_d;
    logic [7:0] run_len_q, run_len_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [7:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        count_d     = count_q;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        fail_code_d = fail_code_q;
        run_len_d   = run_len_q;

        unique case (state_q)
            IDLE: begin
                if (a) state_d = ARMED;
            end
            ARMED: begin
                if (!a && b && c) begin
                    state_d = RUN;
                    count_d = 8'd1;
                end else begin
                    state_d     = IDLE;
                    fail_d      = 1'b1;
                    fail_code_d = CODE_NO_START;
                end
            end
            RUN: begin
                // The run length reported on any exit from RUN is the count before this sample.
                if (a) begin
                    state_d     = IDLE;
                    fail_d      = 1'b1;
                    fail_code_d = CODE_ILLEGAL;
                    run_len_d   = count_q;
                end else if (b && c) begin
                    if (count_q == MAX_L) begin
                        state_d     = IDLE;
                        fail_d      = 1'b1;
                        fail_code_d = CODE_OVERFLOW;
                        run_len_d   = count_q;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else if (b) begin
                    state_d   = IDLE;
                    run_len_d = count_q;
                    if (count_q >= MIN_L) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d      = 1'b1;
                        fail_code_d = CODE_SHORT;
                    end
                end else begin
                    state_d     = IDLE;
                    fail_d      = 1'b1;
                    fail_code_d = CODE_ILLEGAL;
                    run_len_d   = count_q;
                end
            end
            default: state_d = IDLE;
        endcase

        pass_cnt_d = (pass_d && pass_cnt_q != 8'hFF) ? pass_cnt_q + 8'd1 : pass_cnt_q;
        fail_cnt_d = (fail_d && fail_cnt_q != 8'hFF) ? fail_cnt_q + 8'd1 : fail_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= CODE_SHORT;
            run_len_q   <= 8'd0;
            pass_cnt_q  <= 8'd0;
            fail_cnt_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            state_q     <= state_d;
            count_q     <= count_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
            run_len_q   <= run_len_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign busy      = (state_q != IDLE);
    assign run_len   = run_len_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_abc_seq_monitor.sv
// Directed bench for abc_seq_monitor: one instance with default lengths, one with MIN_LEN=3,
// both driven by the same stimulus and checked against hand-computed values.
module tb_abc_seq_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c;
    logic       pass, fail, busy;
    logic [1:0] fail_code;
    logic [7:0] run_len, pass_cnt, fail_cnt;
    logic       pass3, fail3, busy3;
    logic [1:0] fail_code3;
    logic [7:0] run_len3, pass_cnt3, fail_cnt3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    abc_seq_monitor dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .pass(pass), .fail(fail), .fail_code(fail_code), .busy(busy),
        .run_len(run_len), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    abc_seq_monitor #(.MIN_LEN(3), .MAX_LEN(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .pass(pass3), .fail(fail3), .fail_code(fail_code3), .busy(busy3),
        .run_len(run_len3), .pass_cnt(pass_cnt3), .fail_cnt(fail_cnt3)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one sample between edges, then look #1 after the edge that captured it.
    task automatic step(input logic av, input logic bv, input logic cv);
        @(negedge clk);
        a = av;
        b = bv;
        c = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        #12;
        check("rst_pass",     32'(pass),      0);
        check("rst_fail",     32'(fail),      0);
        check("rst_code",     32'(fail_code), 0);
        check("rst_busy",     32'(busy),      0);
        check("rst_run_len",  32'(run_len),   0);
        check("rst_pass_cnt", 32'(pass_cnt),  0);
        check("rst_fail_cnt", 32'(fail_cnt),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Legal run of 7.
        step(1, 0, 0);
        check("t1_busy_armed", 32'(busy), 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 1);
            check("t1_run_nopulse", 32'({pass, fail}), 0);
        end
        step(0, 1, 0);
        check("t1_pass",     32'(pass),     1);
        check("t1_fail",     32'(fail),     0);
        check("t1_run_len",  32'(run_len),  7);
        check("t1_pass_cnt", 32'(pass_cnt), 1);
        check("t1_busy",     32'(busy),     0);
        check("t1_pass3",    32'(pass3),    1);
        step(0, 0, 0);
        check("t1_pulse_one_cycle", 32'(pass), 0);

        // Overflow on the 9th b&&c sample.
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1);
            check("t2_run_nofail", 32'(fail), 0);
        end
        step(0, 1, 1);
        check("t2_fail",     32'(fail),      1);
        check("t2_code",     32'(fail_code), 2);
        check("t2_run_len",  32'(run_len),   8);
        check("t2_fail_cnt", 32'(fail_cnt),  1);
        check("t2_busy",     32'(busy),      0);

        // No start after a.
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check("t3_fail",     32'(fail),      1);
        check("t3_code",     32'(fail_code), 1);
        check("t3_busy",     32'(busy),      0);
        check("t3_run_len",  32'(run_len),   8);
        check("t3_fail_cnt", 32'(fail_cnt),  2);

        // Run of 2: legal for MIN_LEN=1, too short for MIN_LEN=3.
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 1, 0);
        check("t4_pass",      32'(pass),       1);
        check("t4_run_len",   32'(run_len),    2);
        check("t4_pass_cnt",  32'(pass_cnt),   2);
        check("t4_fail3",     32'(fail3),      1);
        check("t4_pass3",     32'(pass3),      0);
        check("t4_code3",     32'(fail_code3), 0);
        check("t4_run_len3",  32'(run_len3),   2);
        check("t4_fail_cnt3", 32'(fail_cnt3),  3);

        // a during RUN is illegal and does not start a new attempt.
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        step(1, 1, 1);
        check("t5_fail",     32'(fail),      1);
        check("t5_code",     32'(fail_code), 3);
        check("t5_run_len",  32'(run_len),   3);
        check("t5_fail_cnt", 32'(fail_cnt),  3);
        check("t5_busy",     32'(busy),      0);
        step(0, 0, 0);
        check("t5_idle_busy", 32'(busy), 0);
        check("t5_idle_nopulse", 32'({pass, fail}), 0);
        step(1, 0, 0);
        check("t5_rearm_busy", 32'(busy), 1);
        step(0, 1, 1);
        step(0, 1, 0);
        check("t5_fresh_pass",    32'(pass),       1);
        check("t5_fresh_run_len", 32'(run_len),    1);
        check("t5_fresh_cnt",     32'(pass_cnt),   3);
        check("t5_fresh_code3",   32'(fail_code3), 0);
        check("t5_fresh_fcnt3",   32'(fail_cnt3),  5);

        // !b in RUN is illegal.
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 0, 1);
        check("t6_fail",     32'(fail),      1);
        check("t6_code",     32'(fail_code), 3);
        check("t6_fail_cnt", 32'(fail_cnt),  4);

        // Reset mid-RUN abandons the attempt.
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy",     32'(busy),      0);
        check("t7_rst_code",     32'(fail_code), 0);
        check("t7_rst_run_len",  32'(run_len),   0);
        check("t7_rst_pass_cnt", 32'(pass_cnt),  0);
        check("t7_rst_fail_cnt", 32'(fail_cnt),  0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0);
        check("t7_no_pulse", 32'({pass, fail}), 0);
        check("t7_busy",     32'(busy),         0);

        // Saturating pass counter.
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 0);
            step(0, 1, 1);
            step(0, 1, 0);
        end
        check("t8_last_pass",     32'(pass),     1);
        check("t8_pass_cnt_sat",  32'(pass_cnt), 255);
        check("t8_fail_cnt",      32'(fail_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/abc_seq_monitor.md
ABC_SEQ_MONITOR -- requirements
Module: abc_seq_monitor

Interface
REQ-001 The block SHALL have parameter MIN_LEN, default 1, minimum legal number of consecutive b&&c samples in a run.
REQ-002 The block SHALL have parameter MAX_LEN, default 8, maximum legal run length; MIN_LEN <= MAX_LEN <= 255.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all sampling and state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  1  start request, sampled.
REQ-007 b  input  1  data-valid, sampled.
REQ-008 c  input  1  run qualifier, sampled.
REQ-009 pass  output  1  one-cycle pulse on a legal sequence completing.
REQ-010 fail  output  1  one-cycle pulse on an illegal sequence.
REQ-011 fail_code  output  2  cause of the most recent fail, held until the next fail: 0 too short, 1 no start, 2 overflow, 3 illegal.
REQ-012 busy  output  1  high while an attempt is in progress (state != IDLE).
REQ-013 run_len  output  8  run length of the last completed attempt.
REQ-014 pass_cnt  output  8  count of passes, saturating at 255.
REQ-015 fail_cnt  output  8  count of fails, saturating at 255.

Function
REQ-016 The legal sequence SHALL be: a, then ##1 (b&&c)[*MIN_LEN:MAX_LEN], then ##1 terminator (!a && b && !c).
REQ-017 The FSM SHALL have exactly three states: IDLE, ARMED and RUN.
REQ-018 IDLE: a=1 SHALL go to ARMED; the b and c values in that sample are ignored; a=0 SHALL stay in IDLE.
REQ-019 ARMED: !a && b && c SHALL go to RUN with count=1; any other sample SHALL fail with code 1 and go to IDLE.
REQ-020 RUN, priority 1: a=1 SHALL fail with code 3 and go to IDLE.
REQ-021 RUN, priority 2: b && c with count==MAX_LEN SHALL fail with code 2 and go to IDLE; otherwise count SHALL increment and the FSM SHALL stay in RUN.
REQ-022 RUN, priority 3: terminator with count>=MIN_LEN SHALL pass; terminator with count<MIN_LEN SHALL fail with code 0; both go to IDLE.
REQ-023 RUN, priority 4: any other sample (!b) SHALL fail with code 3 and go to IDLE.
REQ-024 pass and fail SHALL be registered and asserted in the cycle after the deciding sample edge, i.e. visible one clock after that edge; they are never high together.
REQ-025 run_len SHALL be updated with the count at the deciding edge on every pass, and on every fail from RUN.
REQ-026 pass_cnt and fail_cnt SHALL increment with their pulses and hold at 255.
REQ-027 An a=1 in the same sample that returns the FSM to IDLE SHALL NOT start a new attempt; a new attempt requires a sampled in IDLE.
REQ-028 Overlapping attempts SHALL NOT be supported.
REQ-029 The counter SHALL be 8 bits and SHALL never wrap; overflow is caught by REQ-021 before wrap can occur.

Reset
REQ-030 While rst_n=0 the block SHALL immediately set: state IDLE, count 0, pass 0, fail 0, fail_code 0, busy 0, run_len 0, pass_cnt 0, fail_cnt 0.
REQ-031 Reset asserted mid-attempt SHALL abandon the attempt with no pass or fail pulse.
REQ-032 Sampling SHALL resume on the first rising edge after rst_n rises.

Verification
REQ-033 Defaults; a=1; then b=c=1 for 7 cycles; then b=1,c=0 -> one pass pulse, run_len=7, pass_cnt=1.
REQ-034 Defaults; a=1; then b=c=1 for 9 cycles -> fail on the 9th b&&c sample, fail_code=2, run_len=8.
REQ-035 a=1; next sample a=0,b=0,c=1 -> fail, fail_code=1, busy low the next cycle.
REQ-036 MIN_LEN=3; a=1; b=c=1 for 2 cycles; terminator -> fail, fail_code=0, run_len=2.
REQ-037 In RUN, a=1 together with b=c=1 -> fail, fail_code=3; a new a in IDLE then starts a fresh attempt.
REQ-038 rst_n pulsed low during RUN -> no pulse, all outputs 0; force 256 passes -> pass_cnt holds at 255.
